// File: rtl/gfx_pkg.sv
// Shared definitions for the VRAM arbiter: default VRAM geometry, GPU hold limit
// and the arbiter FSM encoding.
package gfx_pkg;

  localparam int GFX_ADDR_W   = 10;
  localparam int GFX_DATA_W   = 16;
  localparam int GFX_MAX_HOLD = 64;
  localparam int CPU_ADDR_W   = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CPU_ACC   = 3'd1,
    CPU_DONE  = 3'd2,
    GPU_LOCK  = 3'd3,
    GPU_DRAIN = 3'd4
  } arbState_t;

  // Counter width able to hold MAX_HOLD-1, never narrower than one bit.
  function automatic int holdCntWidth(input int maxHold);
    return (maxHold > 1) ? $clog2(maxHold) : 1;
  endfunction

endpackage

// File: rtl/hold_counter.sv
// Counts GPU lock cycles spent while the CPU is waiting; the saturated flag
// tells the arbiter that the GPU has used up its hold budget.
module hold_counter
  import gfx_pkg::*;
#(
  parameter int MAX_HOLD = GFX_MAX_HOLD
)(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic saturated
);

  localparam int CNT_W = holdCntWidth(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] count;

  assign saturated = (count == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !saturated) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates a single-port VRAM between CPU word accesses and exclusive GPU lock
// sessions, with a hold limit that forces the GPU off when the CPU is starved.
module vram_arbiter
  import gfx_pkg::*;
#(
  parameter int ADDR_W   = GFX_ADDR_W,
  parameter int DATA_W   = GFX_DATA_W,
  parameter int MAX_HOLD = GFX_MAX_HOLD
)(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  CPU_REQ,
  input  logic                  CPU_WRITE,
  input  logic [CPU_ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0]     CPU_DATA_W,
  output logic [DATA_W-1:0]     CPU_DATA_R,
  output logic                  CPU_ACK,
  input  logic                  GPU_LOCK_REQ,
  output logic                  GPU_LOCK_GNT,
  input  logic                  GPU_ENABLE,
  input  logic                  GPU_WRITE,
  input  logic [ADDR_W-1:0]     GPU_ADDR,
  input  logic [DATA_W-1:0]     GPU_DATA_W,
  output logic [DATA_W-1:0]     GPU_DATA_R,
  output logic                  GPU_RVALID,
  output logic                  VRAM_ENABLE,
  output logic                  VRAM_WRITE,
  output logic [ADDR_W-1:0]     VRAM_ADDR,
  output logic [DATA_W-1:0]     VRAM_DATA_W,
  input  logic [DATA_W-1:0]     VRAM_DATA_R,
  output arbState_t             dbgState
);

  // Handshakes: CPU_REQ is a valid that stays high with a stable command until
  // the one-cycle CPU_ACK pulse completes it; GPU_LOCK_REQ/GPU_LOCK_GNT are
  // level request/grant, and GPU strobes count only while GPU_LOCK_GNT is high.

  arbState_t       state, stateNext;
  logic            lastCpu;
  logic            gpuRdPend;
  logic [DATA_W-1:0] cpuDataQ;
  logic [DATA_W-1:0] cpuRdNow;
  logic            cpuInRange;
  logic            cpuRdCapture;
  logic            holdSat;

  assign cpuInRange   = ((CPU_ADDR >> ADDR_W) == '0);
  assign cpuRdNow     = cpuInRange ? VRAM_DATA_R : '0;
  assign cpuRdCapture = (state == CPU_DONE) && !CPU_WRITE;

  // Read data is presented together with the ack, then held by cpuDataQ.
  assign CPU_DATA_R = cpuRdCapture ? cpuRdNow : cpuDataQ;
  assign GPU_DATA_R = VRAM_DATA_R;
  assign GPU_RVALID = gpuRdPend;
  assign dbgState   = state;

  hold_counter #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold (
    .clk       (CLK),
    .reset     (RESET),
    .clear     (state != GPU_LOCK),
    .enable    ((state == GPU_LOCK) && CPU_REQ),
    .saturated (holdSat)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      lastCpu   <= 1'b0;
      gpuRdPend <= 1'b0;
      cpuDataQ  <= '0;
    end else begin
      state     <= stateNext;
      gpuRdPend <= (state == GPU_LOCK) && GPU_ENABLE && !GPU_WRITE;
      if (state == IDLE && stateNext == CPU_ACC) begin
        lastCpu <= 1'b1;
      end else if (state == GPU_DRAIN) begin
        lastCpu <= 1'b0;
      end
      if (cpuRdCapture) begin
        cpuDataQ <= cpuRdNow;
      end
    end
  end

  always_comb begin
    stateNext    = state;
    CPU_ACK      = 1'b0;
    GPU_LOCK_GNT = 1'b0;
    VRAM_ENABLE  = 1'b0;
    VRAM_WRITE   = 1'b0;
    VRAM_ADDR    = '0;
    VRAM_DATA_W  = '0;
    case (state)
      IDLE: begin
        // On contention the requester not served last wins.
        if (CPU_REQ && (!GPU_LOCK_REQ || !lastCpu)) begin
          stateNext = CPU_ACC;
        end else if (GPU_LOCK_REQ) begin
          stateNext = GPU_LOCK;
        end
      end
      CPU_ACC: begin
        if (cpuInRange) begin
          VRAM_ENABLE = 1'b1;
          VRAM_WRITE  = CPU_WRITE;
          VRAM_ADDR   = CPU_ADDR[ADDR_W-1:0];
          VRAM_DATA_W = CPU_DATA_W;
        end
        stateNext = CPU_DONE;
      end
      CPU_DONE: begin
        CPU_ACK   = 1'b1;
        stateNext = IDLE;
      end
      GPU_LOCK: begin
        GPU_LOCK_GNT = 1'b1;
        VRAM_ENABLE  = GPU_ENABLE;
        VRAM_WRITE   = GPU_WRITE;
        VRAM_ADDR    = GPU_ADDR;
        VRAM_DATA_W  = GPU_DATA_W;
        if (!GPU_LOCK_REQ || (CPU_REQ && holdSat)) begin
          stateNext = GPU_DRAIN;
        end
      end
      GPU_DRAIN: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

endmodule
